// File: rtl/vending_machine_param_if.sv
// Front-end / dispenser bundle for vending_machine_param.
// master = keypad, coin acceptor and hopper side; slave = controller.
interface vending_machine_param_if #(
  parameter int NUM_ITEMS = 5,
  parameter int IDX_W     = 3,
  parameter int QTY_W     = 2,
  parameter int CREDIT_W  = 6
);
  logic [2:0]           coin;
  logic                 confirm;
  logic                 cancel;
  logic                 restock;
  logic [IDX_W-1:0]     item_sel;
  logic [QTY_W-1:0]     amt_sel;
  logic                 done;
  logic                 refund;
  logic                 coin_reject;
  logic [1:0]           err_code;
  logic [IDX_W-1:0]     item_name;
  logic [QTY_W-1:0]     item_amt;
  logic [CREDIT_W-1:0]  change;
  logic [CREDIT_W-1:0]  credit;
  logic [NUM_ITEMS-1:0] sold_out;

  modport master (
    output coin, confirm, cancel, restock,
    output item_sel, amt_sel,
    input  done, refund, coin_reject, err_code,
    input  item_name, item_amt, change,
    input  credit, sold_out
  );

  modport slave (
    input  coin, confirm, cancel, restock,
    input  item_sel, amt_sel,
    output done, refund, coin_reject, err_code,
    output item_name, item_amt, change,
    output credit, sold_out
  );
endinterface

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: capped credit, per-item stock,
// quantity pricing and exact change in nickels.
module vending_machine_param #(
  parameter int NUM_ITEMS  = 5,
  parameter int IDX_W      = 3,
  parameter int QTY_W      = 2,
  parameter int PRICE_W    = 4,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICES =
    {4'd5, 4'd4, 4'd3, 4'd2, 4'd1},
  parameter int CREDIT_W   = 6,
  parameter int MAX_CREDIT = 20,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 3
) (
  input logic clk,
  input logic rst,
  vending_machine_param_if.slave vm_if
);

  localparam int CW = PRICE_W + QTY_W;
  localparam int MW = (CW > CREDIT_W) ? CW : CREDIT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
  logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
  logic                done_q, done_d;
  logic                refund_q, refund_d;
  logic                rej_q, rej_d;
  logic [1:0]          err_q, err_d;
  logic [IDX_W-1:0]    name_q, name_d;
  logic [QTY_W-1:0]    amt_q, amt_d;
  logic [CREDIT_W-1:0] chg_q, chg_d;

  logic [2:0]          coin_val;
  logic                coin_vld;
  logic [CREDIT_W:0]   coin_sum;
  logic [PRICE_W-1:0]  price_sel;
  logic [STOCK_W-1:0]  stk_sel;
  logic [CW-1:0]       cost;
  logic                sel_ok;

  always_comb begin
    coin_val = 3'd0;
    case (vm_if.coin)
      3'b001:  coin_val = 3'd1;
      3'b010:  coin_val = 3'd2;
      3'b100:  coin_val = 3'd5;
      default: coin_val = 3'd0;
    endcase
  end

  assign coin_vld = (coin_val != 3'd0);
  assign coin_sum = {1'b0, credit_q}
                  + (CREDIT_W+1)'(coin_val);

  always_comb begin
    price_sel = '0;
    stk_sel   = '0;
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (vm_if.item_sel == IDX_W'(k + 1)) begin
        price_sel = PRICES[k*PRICE_W +: PRICE_W];
        stk_sel   = stock_q[k];
      end
    end
  end

  assign cost = CW'(price_sel) * CW'(vm_if.amt_sel);

  assign sel_ok = (vm_if.item_sel != '0)
               && (vm_if.item_sel <= IDX_W'(NUM_ITEMS))
               && (vm_if.amt_sel != '0);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    done_d   = 1'b0;
    refund_d = 1'b0;
    rej_d    = 1'b0;
    err_d    = 2'd0;
    name_d   = '0;
    amt_d    = '0;
    chg_d    = '0;

    if (vm_if.cancel) begin
      rej_d = coin_vld;
      if (credit_q != '0) begin
        refund_d = 1'b1;
        chg_d    = credit_q;
        credit_d = '0;
      end
    end else if (vm_if.confirm) begin
      rej_d = coin_vld;
      if (!sel_ok) begin
        err_d = 2'd3;
      end else if (stk_sel < STOCK_W'(vm_if.amt_sel)) begin
        err_d = 2'd2;
      end else if (MW'(credit_q) < MW'(cost)) begin
        err_d = 2'd1;
      end else begin
        done_d   = 1'b1;
        name_d   = vm_if.item_sel;
        amt_d    = vm_if.amt_sel;
        chg_d    = credit_q - CREDIT_W'(cost);
        credit_d = '0;
        for (int k = 0; k < NUM_ITEMS; k++) begin
          if (vm_if.item_sel == IDX_W'(k + 1))
            stock_d[k] = stock_q[k] - STOCK_W'(vm_if.amt_sel);
        end
      end
    end else if (coin_vld) begin
      if (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT))
        credit_d = coin_sum[CREDIT_W-1:0];
      else
        rej_d = 1'b1;
    end else if (vm_if.restock && state_q == S_IDLE) begin
      for (int k = 0; k < NUM_ITEMS; k++)
        stock_d[k] = STOCK_W'(STOCK_INIT);
    end

    // Vend and error cycles are visible states; others follow credit.
    if (done_d)
      state_d = S_VEND;
    else if (err_d != 2'd0)
      state_d = S_ERR;
    else if (credit_d != '0)
      state_d = S_CREDIT;
    else
      state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      done_q   <= 1'b0;
      refund_q <= 1'b0;
      rej_q    <= 1'b0;
      err_q    <= 2'd0;
      name_q   <= '0;
      amt_q    <= '0;
      chg_q    <= '0;
      for (int k = 0; k < NUM_ITEMS; k++)
        stock_q[k] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      done_q   <= done_d;
      refund_q <= refund_d;
      rej_q    <= rej_d;
      err_q    <= err_d;
      name_q   <= name_d;
      amt_q    <= amt_d;
      chg_q    <= chg_d;
      for (int k = 0; k < NUM_ITEMS; k++)
        stock_q[k] <= stock_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_ITEMS; k++)
      vm_if.sold_out[k] = (stock_q[k] == '0);
  end

  assign vm_if.done        = done_q;
  assign vm_if.refund      = refund_q;
  assign vm_if.coin_reject = rej_q;
  assign vm_if.err_code    = err_q;
  assign vm_if.item_name   = name_q;
  assign vm_if.item_amt    = amt_q;
  assign vm_if.change      = chg_q;
  assign vm_if.credit      = credit_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Scoreboard bench: a cycle-level reference model predicts each response,
// a negedge monitor compares the DUT against the queued predictions.
module tb_vending_machine_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  vending_machine_param_if #(
    .NUM_ITEMS(5), .IDX_W(3), .QTY_W(2), .CREDIT_W(6)
  ) vif ();

  vending_machine_param dut (
    .clk   (clk),
    .rst   (rst),
    .vm_if (vif.slave)
  );

  typedef struct {
    int due;
    int done;
    int refund;
    int rej;
    int err;
    int name;
    int amt;
    int chg;
    int cred;
    int so;
  } exp_t;

  exp_t q[$];

  // Reference model state: credit in nickels, stock per item, and
  // whether the previous cycle was a vend or error response.
  int m_credit;
  int m_stock [1:5];
  int m_busy;

  function automatic int price_of(int k);
    return k;
  endfunction

  function automatic int coin_nickels(int c);
    if (c == 1) return 1;
    if (c == 2) return 2;
    if (c == 4) return 5;
    return 0;
  endfunction

  task automatic model_reset();
    m_credit = 0;
    m_busy   = 0;
    for (int k = 1; k <= 5; k++) m_stock[k] = 3;
  endtask

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d",
               nm, cyc, got, want);
    end
  endtask

  task automatic step(int c, int cf, int cn, int rs, int sel, int amt);
    exp_t e;
    int   v;
    @(posedge clk);
    #1;
    vif.coin     = 3'(c);
    vif.confirm  = cf[0];
    vif.cancel   = cn[0];
    vif.restock  = rs[0];
    vif.item_sel = 3'(sel);
    vif.amt_sel  = 2'(amt);
    e = '{default: 0};
    e.due = cyc + 1;
    v = coin_nickels(c);
    if (cn != 0) begin
      if (v != 0) e.rej = 1;
      if (m_credit > 0) begin
        e.refund = 1;
        e.chg    = m_credit;
        m_credit = 0;
      end
    end else if (cf != 0) begin
      if (v != 0) e.rej = 1;
      if (sel < 1 || sel > 5 || amt == 0)
        e.err = 3;
      else if (m_stock[sel] < amt)
        e.err = 2;
      else if (m_credit < price_of(sel) * amt)
        e.err = 1;
      else begin
        e.done = 1;
        e.name = sel;
        e.amt  = amt;
        e.chg  = m_credit - price_of(sel) * amt;
        m_credit = 0;
        m_stock[sel] -= amt;
      end
    end else if (v != 0) begin
      if (m_credit + v <= 20) m_credit += v;
      else e.rej = 1;
    end else if (rs != 0 && m_credit == 0 && m_busy == 0) begin
      for (int k = 1; k <= 5; k++) m_stock[k] = 3;
    end
    m_busy = (e.done != 0 || e.err != 0) ? 1 : 0;
    e.cred = m_credit;
    for (int k = 1; k <= 5; k++)
      if (m_stock[k] == 0) e.so |= (1 << (k - 1));
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("done",        int'(vif.done),        e.done);
        chk("refund",      int'(vif.refund),      e.refund);
        chk("coin_reject", int'(vif.coin_reject), e.rej);
        chk("err_code",    int'(vif.err_code),    e.err);
        chk("item_name",   int'(vif.item_name),   e.name);
        chk("item_amt",    int'(vif.item_amt),    e.amt);
        chk("change",      int'(vif.change),      e.chg);
        chk("credit",      int'(vif.credit),      e.cred);
        chk("sold_out",    int'(vif.sold_out),    e.so);
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_done"},   int'(vif.done),        0);
    chk({tag, "_refund"}, int'(vif.refund),      0);
    chk({tag, "_rej"},    int'(vif.coin_reject), 0);
    chk({tag, "_err"},    int'(vif.err_code),    0);
    chk({tag, "_name"},   int'(vif.item_name),   0);
    chk({tag, "_amt"},    int'(vif.item_amt),    0);
    chk({tag, "_change"}, int'(vif.change),      0);
    chk({tag, "_credit"}, int'(vif.credit),      0);
    chk({tag, "_soldout"}, int'(vif.sold_out),   0);
  endtask

  task automatic mid_reset();
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    q.delete();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int c, cf, cn, rs;
    vif.coin = 3'b000;
    vif.confirm = 1'b0;
    vif.cancel = 1'b0;
    vif.restock = 1'b0;
    vif.item_sel = '0;
    vif.amt_sel = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Quarter then item C x1
    step(4, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 3, 1);
    // Insufficient credit, then top up and buy
    step(2, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 5, 1);
    step(4, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 5, 1);
    // Credit cap and cancel
    repeat (4) step(4, 0, 0, 0, 0, 0);
    step(4, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    // Sell out item A, re-buy, restock
    step(2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 3);
    step(0, 1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // Invalid selections
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 6, 1);
    step(0, 1, 0, 0, 2, 0);
    // cancel + confirm + coin together
    step(4, 0, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 2, 1);
    // Async reset with credit held
    step(0, 1, 0, 0, 2, 2);
    step(4, 0, 0, 0, 0, 0);
    mid_reset();

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    c = 1;
        2, 3:    c = 2;
        4, 5:    c = 4;
        6:       c = 3 + 4 * $urandom_range(0, 1);
        default: c = 0;
      endcase
      cf = ($urandom_range(0, 99) < 18) ? 1 : 0;
      cn = ($urandom_range(0, 99) < 6) ? 1 : 0;
      rs = ($urandom_range(0, 99) < 12) ? 1 : 0;
      step(c, cf, cn, rs, $urandom_range(0, 7), $urandom_range(0, 3));
      if (i == 1500) mid_reset();
    end

    step(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
